// File: rtl/axi_riscv_w_sync_if.sv
// ---------------------------------------------------------------------------
// axi_riscv_w_sync_if
// Full AXI4(+ATOP) bus bundle used on both sides of axi_riscv_w_sync.
//   Master modport : drives AW/W/AR and B/R ready (initiator side)
//   Slave  modport : drives AW/W/AR ready and B/R (target side)
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH (strobe = /8), AXI_ID_WIDTH,
//             AXI_USER_WIDTH.
// ---------------------------------------------------------------------------
interface axi_riscv_w_sync_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_riscv_w_sync.sv
// ---------------------------------------------------------------------------
// axi_riscv_w_sync
// Write-channel synchroniser in front of the LR/SC adapter. One AW is
// captured, its W burst is buffered, then AW is forwarded followed by the
// buffered beats, so downstream logic never sees an AW without its data.
// AR/R/B pass straight through; B carries an injected SLVERR for bursts
// too long for the buffer.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   slv_port : upstream AXI (Slave modport)
//   mst_port : downstream AXI (Master modport)
// Build option: AXI_RISCV_W_SYNC_CUT_THROUGH_EN -- when defined, bursts longer
// than W_BUF_DEPTH are forwarded cut-through instead of being rejected.
// ---------------------------------------------------------------------------
module axi_riscv_w_sync #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned W_BUF_DEPTH    = 16
) (
    input logic                clk_i,
    input logic                rst_ni,
    axi_riscv_w_sync_if.Slave  slv_port,
    axi_riscv_w_sync_if.Master mst_port
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned PTR_W  = (W_BUF_DEPTH > 1) ? $clog2(W_BUF_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(W_BUF_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, COLLECT, AW_SEND, DRAIN, DISCARD} state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [5:0]                atop;
        logic [AXI_USER_WIDTH-1:0] user;
    } aw_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]         strb;
        logic [AXI_USER_WIDTH-1:0] user;
        logic                      last;
    } beat_t;

    state_e           r_state, w_state_nxt;
    aw_t              r_aw, w_aw_in;
    beat_t            r_mem [W_BUF_DEPTH];
    beat_t            w_beat_in, w_head;
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inj_pend, r_inj_act;
    logic             w_full, w_empty, w_wr_rdy, w_push, w_pop;
    logic             w_aw_hs, w_aw_cap, w_inj_set, w_inj_drv;

    // ---------------- AR / R pass-through ----------------
    assign mst_port.ar_id     = slv_port.ar_id;
    assign mst_port.ar_addr   = slv_port.ar_addr;
    assign mst_port.ar_len    = slv_port.ar_len;
    assign mst_port.ar_size   = slv_port.ar_size;
    assign mst_port.ar_burst  = slv_port.ar_burst;
    assign mst_port.ar_lock   = slv_port.ar_lock;
    assign mst_port.ar_cache  = slv_port.ar_cache;
    assign mst_port.ar_prot   = slv_port.ar_prot;
    assign mst_port.ar_qos    = slv_port.ar_qos;
    assign mst_port.ar_region = slv_port.ar_region;
    assign mst_port.ar_user   = slv_port.ar_user;
    assign mst_port.ar_valid  = slv_port.ar_valid;
    assign slv_port.ar_ready  = mst_port.ar_ready;
    assign slv_port.r_id      = mst_port.r_id;
    assign slv_port.r_data    = mst_port.r_data;
    assign slv_port.r_resp    = mst_port.r_resp;
    assign slv_port.r_last    = mst_port.r_last;
    assign slv_port.r_user    = mst_port.r_user;
    assign slv_port.r_valid   = mst_port.r_valid;
    assign mst_port.r_ready   = slv_port.r_ready;

    // ---------------- AW capture / forward ----------------
    assign w_aw_in = '{id: slv_port.aw_id, addr: slv_port.aw_addr, len: slv_port.aw_len,
                       size: slv_port.aw_size, burst: slv_port.aw_burst, lock: slv_port.aw_lock,
                       cache: slv_port.aw_cache, prot: slv_port.aw_prot, qos: slv_port.aw_qos,
                       region: slv_port.aw_region, atop: slv_port.aw_atop, user: slv_port.aw_user};

    // A pending injected B blocks new AWs so its id (r_aw.id) stays valid.
    assign slv_port.aw_ready  = (r_state == IDLE) && !r_inj_pend;
    assign w_aw_hs            = slv_port.aw_valid && slv_port.aw_ready;
    assign mst_port.aw_valid  = (r_state == AW_SEND);
    assign mst_port.aw_id     = r_aw.id;
    assign mst_port.aw_addr   = r_aw.addr;
    assign mst_port.aw_len    = r_aw.len;
    assign mst_port.aw_size   = r_aw.size;
    assign mst_port.aw_burst  = r_aw.burst;
    assign mst_port.aw_lock   = r_aw.lock;
    assign mst_port.aw_cache  = r_aw.cache;
    assign mst_port.aw_prot   = r_aw.prot;
    assign mst_port.aw_qos    = r_aw.qos;
    assign mst_port.aw_region = r_aw.region;
    assign mst_port.aw_atop   = r_aw.atop;
    assign mst_port.aw_user   = r_aw.user;

    // ---------------- W FIFO (first-word fall-through) ----------------
    assign w_full  = (r_cnt == CNT_W'(W_BUF_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_mem[r_rptr];
    assign w_beat_in = '{data: slv_port.w_data, strb: slv_port.w_strb,
                         user: slv_port.w_user, last: slv_port.w_last};

`ifdef AXI_RISCV_W_SYNC_CUT_THROUGH_EN
    // Set once the beat with last=1 has entered the FIFO; stops further
    // acceptance while the tail of a cut-through burst drains.
    logic r_last_in;
    assign w_wr_rdy = !w_full && ((r_state == COLLECT) || ((r_state == DRAIN) && !r_last_in));
`else
    logic w_long;
    assign w_long   = (32'(slv_port.aw_len) + 32'd1) > W_BUF_DEPTH;
    assign w_wr_rdy = !w_full && (r_state == COLLECT);
`endif

    assign slv_port.w_ready = w_wr_rdy || (r_state == DISCARD);
    assign w_push           = slv_port.w_valid && w_wr_rdy;
    assign mst_port.w_valid = (r_state == DRAIN) && !w_empty;
    assign mst_port.w_data  = w_head.data;
    assign mst_port.w_strb  = w_head.strb;
    assign mst_port.w_user  = w_head.user;
    assign mst_port.w_last  = w_head.last;
    assign w_pop            = mst_port.w_valid && mst_port.w_ready;

    // ---------------- FSM next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_aw_cap    = 1'b0;
        w_inj_set   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_aw_hs) begin
                    w_aw_cap = 1'b1;
`ifdef AXI_RISCV_W_SYNC_CUT_THROUGH_EN
                    w_state_nxt = COLLECT;
`else
                    w_state_nxt = w_long ? DISCARD : COLLECT;
`endif
                end
            end
            COLLECT: begin
                if (w_push && slv_port.w_last) w_state_nxt = AW_SEND;
`ifdef AXI_RISCV_W_SYNC_CUT_THROUGH_EN
                else if (w_full)               w_state_nxt = AW_SEND;
`endif
            end
            AW_SEND: if (mst_port.aw_ready) w_state_nxt = DRAIN;
            DRAIN:   if (w_pop && w_head.last) w_state_nxt = IDLE;
            DISCARD: begin
                if (slv_port.w_valid && slv_port.w_last) begin
                    w_inj_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- B channel with SLVERR injection ----------------
    // Injection waits for an in-flight downstream B to finish; once it has
    // been presented it is held (r_inj_act) until accepted upstream.
    assign w_inj_drv        = r_inj_pend && (r_inj_act || !mst_port.b_valid);
    assign slv_port.b_valid = w_inj_drv ? 1'b1   : mst_port.b_valid;
    assign slv_port.b_id    = w_inj_drv ? r_aw.id : mst_port.b_id;
    assign slv_port.b_resp  = w_inj_drv ? 2'b10  : mst_port.b_resp;
    assign slv_port.b_user  = w_inj_drv ? '0     : mst_port.b_user;
    assign mst_port.b_ready = w_inj_drv ? 1'b0   : slv_port.b_ready;

    // ---------------- state ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_aw       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_inj_pend <= 1'b0;
            r_inj_act  <= 1'b0;
`ifdef AXI_RISCV_W_SYNC_CUT_THROUGH_EN
            r_last_in  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_cap) r_aw <= w_aw_in;
            if (w_push) r_wptr <= (r_wptr == PTR_W'(W_BUF_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PTR_W'(W_BUF_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
            if (w_inj_set)                              r_inj_pend <= 1'b1;
            else if (w_inj_drv && slv_port.b_ready)     r_inj_pend <= 1'b0;
            r_inj_act <= w_inj_drv && !slv_port.b_ready;
`ifdef AXI_RISCV_W_SYNC_CUT_THROUGH_EN
            if (w_aw_cap)                        r_last_in <= 1'b0;
            else if (w_push && slv_port.w_last)  r_last_in <= 1'b1;
`endif
        end
    end

    // Storage needs no reset: occupancy is tracked by r_cnt.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= w_beat_in;
    end
endmodule

// File: tb/tb_axi_riscv_w_sync.sv
module tb_axi_riscv_w_sync;
    localparam int unsigned AW = 32, DW = 32, IW = 4, UW = 1, DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    axi_riscv_w_sync_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) slv();
    axi_riscv_w_sync_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) mst();

    axi_riscv_w_sync #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
        .AXI_USER_WIDTH(UW), .W_BUF_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .slv_port(slv.Slave), .mst_port(mst.Master)
    );

    typedef struct packed { logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } exp_aw_t;
    typedef struct packed { logic [DW-1:0] data; logic [3:0] strb; logic last; } exp_w_t;
    typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } exp_b_t;

    exp_aw_t       q_aw[$];
    exp_w_t        q_w[$];
    exp_b_t        q_b[$];
    logic [IW-1:0] bq[$];          // ids the downstream slave model will answer
    logic [IW-1:0] last_mst_aw_id = '0;
    logic          aw_rdy_en = 1'b1;
    logic          w_toggle  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [DW-1:0] bdata(input logic [DW-1:0] base, input int i);
        return base + DW'(i);
    endfunction
    function automatic logic [3:0] bstrb(input int i);
        return 4'hF ^ 4'(i);
    endfunction

    // expected downstream AW + beats + upstream OKAY B for a forwarded burst
    task automatic expect_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input int len, input logic [DW-1:0] base);
        q_aw.push_back('{id: id, addr: addr, len: 8'(len)});
        for (int i = 0; i <= len; i++)
            q_w.push_back('{data: bdata(base, i), strb: bstrb(i), last: (i == len)});
        q_b.push_back('{id: id, resp: 2'b00});
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len);
        bit ok = 0;
        slv.aw_id = id; slv.aw_addr = addr; slv.aw_len = 8'(len); slv.aw_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (slv.aw_ready) begin ok = 1; break; end
        end
        if (!ok) bound_fail("aw_send");
        @(posedge clk); #1;
        slv.aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] data, input logic [3:0] strb, input logic last);
        bit ok = 0;
        slv.w_data = data; slv.w_strb = strb; slv.w_last = last; slv.w_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (slv.w_ready) begin ok = 1; break; end
        end
        if (!ok) bound_fail("w_send");
        @(posedge clk); #1;
        slv.w_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q_aw.size() == 0 && q_w.size() == 0 && q_b.size() == 0 && bq.size() == 0 &&
                !mst.b_valid && !slv.b_valid) begin ok = 1; break; end
        end
        if (!ok) bound_fail(tag);
        @(posedge clk); #1;
    endtask

    // downstream ready driver (sole driver of mst aw_ready / w_ready)
    initial begin
        mst.aw_ready = 1'b1;
        mst.w_ready  = 1'b1;
        forever begin
            @(posedge clk); #1;
            mst.aw_ready = aw_rdy_en;
            mst.w_ready  = w_toggle ? !mst.w_ready : 1'b1;
        end
    end

    // downstream B responder
    initial begin
        bit hs;
        mst.b_valid = 1'b0; mst.b_id = '0; mst.b_resp = 2'b00; mst.b_user = '0;
        forever begin
            @(negedge clk);
            hs = mst.b_valid && mst.b_ready;
            @(posedge clk); #1;
            if (hs) mst.b_valid = 1'b0;
            if (!mst.b_valid && bq.size() > 0) begin
                mst.b_id = bq.pop_front(); mst.b_resp = 2'b00; mst.b_valid = 1'b1;
            end
        end
    end

    // scoreboard monitor
    initial begin
        exp_aw_t ea;
        exp_w_t  ew;
        bit      found;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mst.aw_valid && mst.aw_ready) begin
                    last_mst_aw_id = mst.aw_id;
                    if (q_aw.size() == 0) bound_fail("mst_aw_unexpected");
                    else begin
                        ea = q_aw.pop_front();
                        chk("mst_aw_id", 64'(mst.aw_id), 64'(ea.id));
                        chk("mst_aw_addr", 64'(mst.aw_addr), 64'(ea.addr));
                        chk("mst_aw_len", 64'(mst.aw_len), 64'(ea.len));
                    end
                end
                if (mst.w_valid && mst.w_ready) begin
                    if (mst.w_last) bq.push_back(last_mst_aw_id);
                    if (q_w.size() == 0) bound_fail("mst_w_unexpected");
                    else begin
                        ew = q_w.pop_front();
                        chk("mst_w_data", 64'(mst.w_data), 64'(ew.data));
                        chk("mst_w_strb", 64'(mst.w_strb), 64'(ew.strb));
                        chk("mst_w_last", 64'(mst.w_last), 64'(ew.last));
                    end
                end
                if (slv.b_valid && slv.b_ready) begin
                    found = 0;
                    for (int i = 0; i < q_b.size(); i++) begin
                        if (q_b[i].id == slv.b_id && q_b[i].resp == slv.b_resp) begin
                            q_b.delete(i); found = 1; break;
                        end
                    end
                    n_tests++;
                    if (!found) begin
                        n_fail++;
                        $display("FAIL slv_b: got id=%0d resp=%0d, not among expected responses",
                                 slv.b_id, slv.b_resp);
                    end
                end
            end
        end
    end

    initial begin
        slv.aw_valid = 0; slv.aw_id = '0; slv.aw_addr = '0; slv.aw_len = '0; slv.aw_size = 3'd2;
        slv.aw_burst = 2'b01; slv.aw_lock = 0; slv.aw_cache = '0; slv.aw_prot = '0; slv.aw_qos = '0;
        slv.aw_region = '0; slv.aw_atop = '0; slv.aw_user = '0;
        slv.w_valid = 0; slv.w_data = '0; slv.w_strb = '0; slv.w_last = 0; slv.w_user = '0;
        slv.b_ready = 1;
        slv.ar_valid = 0; slv.ar_id = '0; slv.ar_addr = '0; slv.ar_len = '0; slv.ar_size = '0;
        slv.ar_burst = '0; slv.ar_lock = 0; slv.ar_cache = '0; slv.ar_prot = '0; slv.ar_qos = '0;
        slv.ar_region = '0; slv.ar_user = '0; slv.r_ready = 0;
        mst.ar_ready = 0; mst.r_valid = 0; mst.r_id = '0; mst.r_data = '0; mst.r_resp = '0;
        mst.r_last = 0; mst.r_user = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_mst_aw_valid", 64'(mst.aw_valid), 64'd0);
        chk("rst_mst_w_valid", 64'(mst.w_valid), 64'd0);
        chk("rst_slv_w_ready", 64'(slv.w_ready), 64'd0);
        chk("rst_slv_aw_ready", 64'(slv.aw_ready), 64'd1);
        chk("rst_slv_b_valid", 64'(slv.b_valid), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // AR / R pass-through
        slv.ar_id = 4'd9; slv.ar_addr = 32'h0000_ABC0; slv.ar_valid = 1; mst.ar_ready = 1;
        #1;
        chk("ar_addr", 64'(mst.ar_addr), 64'h0000_ABC0);
        chk("ar_id", 64'(mst.ar_id), 64'd9);
        chk("ar_valid", 64'(mst.ar_valid), 64'd1);
        chk("ar_ready", 64'(slv.ar_ready), 64'd1);
        mst.r_id = 4'd3; mst.r_data = 32'h5A5A_0001; mst.r_last = 1; mst.r_valid = 1; slv.r_ready = 1;
        #1;
        chk("r_data", 64'(slv.r_data), 64'h5A5A_0001);
        chk("r_id", 64'(slv.r_id), 64'd3);
        chk("r_valid", 64'(slv.r_valid), 64'd1);
        chk("r_ready", 64'(mst.r_ready), 64'd1);
        slv.ar_valid = 0; mst.ar_ready = 0; mst.r_valid = 0; slv.r_ready = 0;
        @(posedge clk); #1;

        // single beat, id=3
        q_aw.push_back('{id: 4'd3, addr: 32'h100, len: 8'd0});
        q_w.push_back('{data: 32'hDEAD_BEEF, strb: 4'hF, last: 1'b1});
        q_b.push_back('{id: 4'd3, resp: 2'b00});
        aw_send(4'd3, 32'h100, 0);
        w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
        chk("single_aw_latency", 64'(mst.aw_valid), 64'd1);
        @(negedge clk);
        chk("single_w_before_aw_hs", 64'(mst.w_valid), 64'd0);
        @(negedge clk);
        chk("single_w_after_aw_hs", 64'(mst.w_valid), 64'd1);
        wait_idle("single_done");

        // len=15, W offered before AW
        slv.w_data = bdata(32'h2000_0000, 0); slv.w_strb = bstrb(0); slv.w_last = 0; slv.w_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("w_before_aw_ready", 64'(slv.w_ready), 64'd0);
        end
        @(posedge clk); #1;
        expect_burst(4'd1, 32'h200, 15, 32'h2000_0000);
        aw_send(4'd1, 32'h200, 15);
        for (int i = 0; i < 16; i++) begin
            w_send(bdata(32'h2000_0000, i), bstrb(i), i == 15);
            if (i < 15) chk("burst16_aw_early", 64'(mst.aw_valid), 64'd0);
        end
        chk("burst16_aw_after_last", 64'(mst.aw_valid), 64'd1);
        wait_idle("burst16_done");

        // backpressure: AW held, then W ready toggling
        aw_rdy_en = 1'b0;
        expect_burst(4'd2, 32'h300, 3, 32'h3000_0000);
        aw_send(4'd2, 32'h300, 3);
        for (int i = 0; i < 4; i++) w_send(bdata(32'h3000_0000, i), bstrb(i), i == 3);
        repeat (5) begin
            @(negedge clk);
            chk("bp_aw_valid", 64'(mst.aw_valid), 64'd1);
            chk("bp_aw_addr", 64'(mst.aw_addr), 64'h300);
            chk("bp_aw_id", 64'(mst.aw_id), 64'd2);
            chk("bp_aw_len", 64'(mst.aw_len), 64'd3);
            chk("bp_slv_w_ready", 64'(slv.w_ready), 64'd0);
            chk("bp_slv_aw_ready", 64'(slv.aw_ready), 64'd0);
        end
        @(posedge clk); #1;
        aw_rdy_en = 1'b1;
        w_toggle  = 1'b1;
        wait_idle("bp_done");
        w_toggle = 1'b0;
        repeat (2) @(posedge clk); #1;

`ifdef AXI_RISCV_W_SYNC_CUT_THROUGH_EN
        // len=31 streamed cut-through
        expect_burst(4'd4, 32'h400, 31, 32'h4000_0000);
        aw_send(4'd4, 32'h400, 31);
        for (int i = 0; i < 32; i++) w_send(bdata(32'h4000_0000, i), bstrb(i), i == 31);
        wait_idle("cut_through_done");
`else
        // len=31 rejected: SLVERR injected alongside a stray downstream B id=5
        aw_send(4'd6, 32'h600, 31);
        q_b.push_back('{id: 4'd6, resp: 2'b10});
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                slv.b_ready = 1'b0;
                q_b.push_back('{id: 4'd5, resp: 2'b00});
                bq.push_back(4'd5);
                repeat (3) @(posedge clk); #1;
            end
            w_send(bdata(32'h6000_0000, i), bstrb(i), i == 31);
        end
        chk("reject_aw_blocked", 64'(slv.aw_ready), 64'd0);
        chk("reject_passthru_b_id", 64'(slv.b_id), 64'd5);
        chk("reject_passthru_b_valid", 64'(slv.b_valid), 64'd1);
        repeat (2) @(posedge clk); #1;
        slv.b_ready = 1'b1;
        wait_idle("reject_done");
        chk("reject_aw_reopened", 64'(slv.aw_ready), 64'd1);
`endif

        // reset in the middle of collecting 4 of 8 beats
        aw_send(4'd7, 32'h700, 7);
        for (int i = 0; i < 4; i++) w_send(bdata(32'h7000_0000, i), bstrb(i), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_aw_valid", 64'(mst.aw_valid), 64'd0);
        chk("midrst_w_valid", 64'(mst.w_valid), 64'd0);
        chk("midrst_w_ready", 64'(slv.w_ready), 64'd0);
        chk("midrst_aw_ready", 64'(slv.aw_ready), 64'd1);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        q_aw.push_back('{id: 4'd8, addr: 32'h800, len: 8'd0});
        q_w.push_back('{data: 32'h1234_5678, strb: 4'hF, last: 1'b1});
        q_b.push_back('{id: 4'd8, resp: 2'b00});
        aw_send(4'd8, 32'h800, 0);
        w_send(32'h1234_5678, 4'hF, 1'b1);
        wait_idle("post_reset_done");

        chk("left_aw", 64'(q_aw.size()), 64'd0);
        chk("left_w", 64'(q_w.size()), 64'd0);
        chk("left_b", 64'(q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
